// File: rtl/arbiter_pkg.sv
// rtl/arbiter_pkg.sv - shared helpers and reset values for the round-robin arbiter
package arbiter_pkg;

    localparam int PTR_RST   = 0;
    localparam int GRANT_RST = 0;

    // Never returns less than 1 so that grant_id always has at least one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arbiter_rr_n_rr_pick.sv
// rtl/arbiter_rr_n_rr_pick.sv - combinational rotating-priority picker
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [N-1:0]   gnt_onehot,
    output logic [IDW-1:0] gnt_idx,
    output logic           any
);

    logic [2*N-1:0] dbl;
    logic           found;

    // Upper copy keeps every request, lower copy drops those below ptr, so an
    // LSB-first scan over the doubled vector yields the wrapped search order.
    always_comb begin
        dbl = {req, req};
        for (int i = 0; i < N; i++) begin
            if (i < int'(ptr)) dbl[i] = 1'b0;
        end
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        for (int i = 0; i < 2 * N; i++) begin
            if (!found && dbl[i]) begin
                found             = 1'b1;
                gnt_idx           = IDW'(i % N);
                gnt_onehot[i % N] = 1'b1;
            end
        end
        any = found;
    end

endmodule

// File: rtl/arbiter_rr_n.sv
// rtl/arbiter_rr_n.sv - N-channel round-robin arbiter with registered output and packet lock
module arbiter_rr_n
    import arbiter_pkg::*;
#(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int PACKET = 0,
    localparam int IDW   = clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    valid_in,
    input  logic [N*DW-1:0] data_in,
    input  logic [N-1:0]    last_in,
    output logic [N-1:0]    ready_out,
    output logic            valid_out,
    output logic [DW-1:0]   data_out,
    output logic [IDW-1:0]  grant_id,
    input  logic            ready_in
);

    logic [IDW-1:0] ptr;
    logic           lock;
    logic [IDW-1:0] lock_ch;

    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;

    logic [N-1:0]   sel_onehot;
    logic [IDW-1:0] sel;
    logic [IDW-1:0] sel_next;
    logic [DW-1:0]  sel_data;
    logic           sel_last;
    logic           slot_free;
    logic           accept;

    rr_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req        (valid_in),
        .ptr        (ptr),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_onehot = '0;
        if (lock) begin
            sel_onehot[lock_ch] = 1'b1;
            sel                 = lock_ch;
        end else begin
            if (pick_any) sel_onehot = pick_onehot;
            sel = pick_idx;
        end
    end

    assign slot_free = !valid_out || ready_in;
    // rst_n gating keeps every ready low while the block is held in reset.
    assign ready_out = (slot_free && rst_n) ? sel_onehot : '0;
    assign accept    = |(valid_in & ready_out);
    assign sel_data  = data_in[int'(sel) * DW +: DW];
    assign sel_last  = |(last_in & sel_onehot);
    assign sel_next  = (sel == IDW'(N - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= IDW'(PTR_RST);
            lock      <= 1'b0;
            lock_ch   <= '0;
            valid_out <= 1'b0;
            data_out  <= '0;
            grant_id  <= IDW'(GRANT_RST);
        end else begin
            if (accept) begin
                valid_out <= 1'b1;
                data_out  <= sel_data;
                grant_id  <= sel;
                if (PACKET == 0 || sel_last) begin
                    ptr  <= sel_next;
                    lock <= 1'b0;
                end else begin
                    lock    <= 1'b1;
                    lock_ch <= sel;
                end
            end else if (ready_in) begin
                valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arbiter_rr_n.sv
// tb/tb_arbiter_rr_n.sv - self-checking bench for arbiter_rr_n in beat and packet modes
module tb_arbiter_rr_n;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // beat-mode instance
    logic        rst_n0;
    logic [3:0]  valid_in0;
    logic [31:0] data_in0;
    logic [3:0]  last_in0;
    logic [3:0]  ready_out0;
    logic        valid_out0;
    logic [7:0]  data_out0;
    logic [1:0]  grant_id0;
    logic        ready_in0;

    // packet-mode instance
    logic        rst_n1;
    logic [3:0]  valid_in1;
    logic [31:0] data_in1;
    logic [3:0]  last_in1;
    logic [3:0]  ready_out1;
    logic        valid_out1;
    logic [7:0]  data_out1;
    logic [1:0]  grant_id1;
    logic        ready_in1;

    arbiter_rr_n #(.N(4), .DW(8), .PACKET(0)) dut0 (
        .clk       (clk),
        .rst_n     (rst_n0),
        .valid_in  (valid_in0),
        .data_in   (data_in0),
        .last_in   (last_in0),
        .ready_out (ready_out0),
        .valid_out (valid_out0),
        .data_out  (data_out0),
        .grant_id  (grant_id0),
        .ready_in  (ready_in0)
    );

    arbiter_rr_n #(.N(4), .DW(8), .PACKET(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n1),
        .valid_in  (valid_in1),
        .data_in   (data_in1),
        .last_in   (last_in1),
        .ready_out (ready_out1),
        .valid_out (valid_out1),
        .data_out  (data_out1),
        .grant_id  (grant_id1),
        .ready_in  (ready_in1)
    );

    int checks   = 0;
    int failures = 0;

    // expected beats: {grant_id, data}
    logic [9:0] sb0[$];
    logic [9:0] sb1[$];

    task automatic test_reset();
        rst_n0 = 1'b0; rst_n1 = 1'b0;
        valid_in0 = 4'b1111; data_in0 = 32'h87654321; last_in0 = 4'b0000; ready_in0 = 1'b1;
        valid_in1 = 4'b1111; data_in1 = 32'h87654321; last_in1 = 4'b0000; ready_in1 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready_out0 !== 4'b0000) begin
            failures++; $display("FAIL reset_ready0 got=%b exp=0000", ready_out0);
        end
        checks++;
        if (valid_out0 !== 1'b0 || data_out0 !== 8'h00 || grant_id0 !== 2'd0) begin
            failures++; $display("FAIL reset_out0 got v=%b d=%h g=%0d exp v=0 d=00 g=0", valid_out0, data_out0, grant_id0);
        end
        checks++;
        if (ready_out1 !== 4'b0000 || valid_out1 !== 1'b0 || data_out1 !== 8'h00) begin
            failures++; $display("FAIL reset_out1 got r=%b v=%b d=%h exp r=0000 v=0 d=00", ready_out1, valid_out1, data_out1);
        end
        valid_in1 = 4'b0000;
        rst_n1 = 1'b1;
    endtask

    task automatic test_all_request();
        logic [9:0] exp;
        sb0.push_back({2'd0, 8'h21});
        sb0.push_back({2'd1, 8'h43});
        sb0.push_back({2'd2, 8'h65});
        sb0.push_back({2'd3, 8'h87});
        sb0.push_back({2'd0, 8'h21});
        rst_n0 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (sb0.size() == 0) begin
                failures++; $display("FAIL all_req_empty beat=%0d got=%h exp=none", i, data_out0);
            end else begin
                exp = sb0.pop_front();
                if (valid_out0 !== 1'b1 || {grant_id0, data_out0} !== exp) begin
                    failures++;
                    $display("FAIL all_req beat=%0d got v=%b g=%0d d=%h exp g=%0d d=%h", i, valid_out0, grant_id0, data_out0, exp[9:8], exp[7:0]);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [9:0] exp;
        sb0.push_back({2'd1, 8'h43});
        @(posedge clk); #1;
        exp = sb0.pop_front();
        checks++;
        if (valid_out0 !== 1'b1 || {grant_id0, data_out0} !== exp) begin
            failures++; $display("FAIL bp_pre got g=%0d d=%h exp g=%0d d=%h", grant_id0, data_out0, exp[9:8], exp[7:0]);
        end
        ready_in0 = 1'b0;
        #1;
        checks++;
        if (ready_out0 !== 4'b0000) begin
            failures++; $display("FAIL bp_ready got=%b exp=0000", ready_out0);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_out0 !== 1'b1 || data_out0 !== 8'h43 || grant_id0 !== 2'd1) begin
            failures++; $display("FAIL bp_hold got v=%b g=%0d d=%h exp v=1 g=1 d=43", valid_out0, grant_id0, data_out0);
        end
        ready_in0 = 1'b1;
        sb0.push_back({2'd2, 8'h65});
        sb0.push_back({2'd3, 8'h87});
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            exp = sb0.pop_front();
            checks++;
            if (valid_out0 !== 1'b1 || {grant_id0, data_out0} !== exp) begin
                failures++; $display("FAIL bp_resume beat=%0d got g=%0d d=%h exp g=%0d d=%h", i, grant_id0, data_out0, exp[9:8], exp[7:0]);
            end
        end
        valid_in0 = 4'b0000;
        @(posedge clk); #1;
        checks++;
        if (valid_out0 !== 1'b0 || data_out0 !== 8'h87) begin
            failures++; $display("FAIL drain got v=%b d=%h exp v=0 d=87", valid_out0, data_out0);
        end
    endtask

    task automatic test_sparse_wrap();
        logic [9:0] exp;
        valid_in0 = 4'b0001;
        sb0.push_back({2'd0, 8'h21});
        @(posedge clk); #1;
        exp = sb0.pop_front();
        checks++;
        if (valid_out0 !== 1'b1 || {grant_id0, data_out0} !== exp) begin
            failures++; $display("FAIL sparse_setup got g=%0d d=%h exp g=0 d=21", grant_id0, data_out0);
        end
        valid_in0 = 4'b1001;
        sb0.push_back({2'd3, 8'h87});
        sb0.push_back({2'd0, 8'h21});
        sb0.push_back({2'd3, 8'h87});
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            exp = sb0.pop_front();
            checks++;
            if (valid_out0 !== 1'b1 || {grant_id0, data_out0} !== exp) begin
                failures++; $display("FAIL sparse beat=%0d got g=%0d d=%h exp g=%0d d=%h", i, grant_id0, data_out0, exp[9:8], exp[7:0]);
            end
        end
        valid_in0 = 4'b0000;
        @(posedge clk); #1;
    endtask

    task automatic test_packet_lock();
        logic [9:0] exp;
        valid_in1 = 4'b0110;
        last_in1  = 4'b0100;
        data_in1  = 32'h00A11100;
        sb1.push_back({2'd1, 8'h11});
        @(posedge clk); #1;
        exp = sb1.pop_front();
        checks++;
        if (valid_out1 !== 1'b1 || {grant_id1, data_out1} !== exp) begin
            failures++; $display("FAIL pkt_beat1 got g=%0d d=%h exp g=1 d=11", grant_id1, data_out1);
        end
        data_in1[15:8] = 8'h12;
        sb1.push_back({2'd1, 8'h12});
        @(posedge clk); #1;
        exp = sb1.pop_front();
        checks++;
        if (valid_out1 !== 1'b1 || {grant_id1, data_out1} !== exp) begin
            failures++; $display("FAIL pkt_beat2 got g=%0d d=%h exp g=1 d=12", grant_id1, data_out1);
        end
        valid_in1[1] = 1'b0;
        #1;
        checks++;
        if (ready_out1 !== 4'b0010) begin
            failures++; $display("FAIL pkt_gap_ready got=%b exp=0010", ready_out1);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks++;
            if (valid_out1 !== 1'b0 || data_out1 !== 8'h12) begin
                failures++; $display("FAIL pkt_gap cyc=%0d got v=%b g=%0d d=%h exp v=0 d=12", i, valid_out1, grant_id1, data_out1);
            end
        end
        valid_in1[1] = 1'b1;
        last_in1[1]  = 1'b1;
        data_in1[15:8] = 8'h13;
        sb1.push_back({2'd1, 8'h13});
        @(posedge clk); #1;
        exp = sb1.pop_front();
        checks++;
        if (valid_out1 !== 1'b1 || {grant_id1, data_out1} !== exp) begin
            failures++; $display("FAIL pkt_last got g=%0d d=%h exp g=1 d=13", grant_id1, data_out1);
        end
        valid_in1[1] = 1'b0;
        sb1.push_back({2'd2, 8'hA1});
        @(posedge clk); #1;
        exp = sb1.pop_front();
        checks++;
        if (valid_out1 !== 1'b1 || {grant_id1, data_out1} !== exp) begin
            failures++; $display("FAIL pkt_next got g=%0d d=%h exp g=2 d=a1", grant_id1, data_out1);
        end
    endtask

    task automatic test_async_reset();
        valid_in1 = 4'b1111;
        last_in1  = 4'b0000;
        data_in1  = 32'h44332211;
        @(posedge clk); #1;
        checks++;
        if (valid_out1 !== 1'b1 || grant_id1 !== 2'd3 || data_out1 !== 8'h44) begin
            failures++; $display("FAIL ar_lockbeat got v=%b g=%0d d=%h exp v=1 g=3 d=44", valid_out1, grant_id1, data_out1);
        end
        #2;
        rst_n1 = 1'b0;
        #1;
        checks++;
        if (valid_out1 !== 1'b0 || ready_out1 !== 4'b0000 || data_out1 !== 8'h00) begin
            failures++; $display("FAIL ar_immediate got v=%b r=%b d=%h exp v=0 r=0000 d=00", valid_out1, ready_out1, data_out1);
        end
        @(posedge clk); #1;
        last_in1 = 4'b1111;
        rst_n1   = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (valid_out1 !== 1'b1 || grant_id1 !== 2'd0 || data_out1 !== 8'h11) begin
            failures++; $display("FAIL ar_restart got v=%b g=%0d d=%h exp v=1 g=0 d=11", valid_out1, grant_id1, data_out1);
        end
        @(posedge clk); #1;
        checks++;
        if (valid_out1 !== 1'b1 || grant_id1 !== 2'd1 || data_out1 !== 8'h22) begin
            failures++; $display("FAIL ar_rotate got v=%b g=%0d d=%h exp v=1 g=1 d=22", valid_out1, grant_id1, data_out1);
        end
    endtask

    initial begin
        test_reset();
        test_all_request();
        test_back_pressure();
        test_sparse_wrap();
        test_packet_lock();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
